debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//   Parametrised multi-channel debouncer for push-buttons, switches and other slow mechanical inputs.
//   Each channel filters its raw input and holds a stable level. It also emits single-cycle rise and fall strobes.
//   Sits between board-level pins and the control FSMs/counters that consume clean levels or edge events.
// PARAMETERS
//   NUM_CH          4    number of independent channels (>=1)
//   DEBOUNCE_LIMIT  20   consecutive differing samples required to accept a new level (>=1)
//   RESET_LEVEL     1'b0 debounced level (and sync-flop value) loaded on reset, applied to all channels
// PORTS
//   clk          input   1       single system clock; all logic on rising edge
//   rst          input   1       reset, synchronous, active-high
//   i_bouncy     input   NUM_CH  raw per-channel inputs (may be asynchronous)
//   o_debounced  output  NUM_CH  filtered stable level per channel
//   o_rise       output  NUM_CH  1-cycle strobe: channel level accepted 0->1
//   o_fall       output  NUM_CH  1-cycle strobe: channel level accepted 1->0
//   o_any_edge   output  1       registered OR of o_rise|o_fall, same cycle as the strobes
// BEHAVIOUR
//   - Reset (rst=1 at clk edge):
//     - o_debounced = {NUM_CH{RESET_LEVEL}}; counters = 0; o_rise = o_fall = 0; o_any_edge = 0.
//     - Mid-operation reset discards any partially counted transition.
//   - Per channel, sample s = i_bouncy[n] (or its synchronised copy), state q = o_debounced[n], counter c.
//     - Counter width: max(1, $clog2(DEBOUNCE_LIMIT)) bits, unsigned.
//   - Per-edge rules (priority order):
//     - s == q: c <= 0. A single matching sample restarts the count, so glitches shorter than LIMIT never pass.
//     - s != q and c == DEBOUNCE_LIMIT-1: q <= s; c <= 0; pulse o_rise (s=1) or o_fall (s=0) for exactly one cycle.
//     - s != q otherwise: c <= c + 1.
//     - Commit requires the input to still differ. Unlike the first-generation block, a count at limit with input
//       returned to q does NOT commit.
//   - Latency:
//     - o_debounced changes on the DEBOUNCE_LIMIT-th consecutive edge at which s != q.
//     - LIMIT=1 gives 1-cycle registered pass-through.
//   - Strobes and counter:
//     - Strobes are registered and assert in the same cycle o_debounced first shows the new level.
//     - Never both rise and fall on one channel in one cycle.
//     - Counter never exceeds LIMIT-1 and never wraps.
//     - A sustained differing input commits exactly once, after which s == q holds c at 0.
//   - Channels are fully independent: simultaneous commits on several channels each strobe in the same cycle,
//     and o_any_edge = 1.
// CONFIGURATION
//   DEBOUNCE_SYNC_EN defined:
//     - Each i_bouncy bit passes through a 2-flop synchroniser (reset to RESET_LEVEL) before the filter.
//     - Adds exactly 2 cycles of latency.
//   DEBOUNCE_SYNC_EN undefined:
//     - s = i_bouncy[n] directly.
//     - Inputs must already be synchronous to clk.
// STRUCTURE
//   - Package debounce_pkg:
//     - localparam/function computing counter width max(1,$clog2(limit)).
//     - Typedef for the per-channel counter.
//   - Sub-module debounce_ch:
//     - Single channel: optional sync, counter, level, rise/fall.
//     - Instantiated NUM_CH times via generate.
//   - Top level:
//     - Concatenates the debounce_ch outputs.
//     - Registers o_any_edge from the next-state strobes so it aligns with o_rise/o_fall.
// TESTING  (NUM_CH=4, DEBOUNCE_LIMIT=4, RESET_LEVEL=0; sync latency +2 when DEBOUNCE_SYNC_EN)
//   1. Reset state:
//      - Stimulus: hold rst 3 cycles with i_bouncy=4'hF.
//      - Required: o_debounced=0, no strobes.
//      - Then release: ch0-3 rise exactly 4 edges later, o_rise=4'hF for 1 cycle, o_any_edge=1.
//   2. Glitch reject:
//      - Stimulus: ch0 high for 3 cycles, low for 1 cycle, repeated 5 times.
//      - Required: o_debounced[0] stays 0; o_rise[0] never asserts.
//   3. Clean press/release:
//      - Stimulus: ch1 high for 10 cycles, then low.
//      - Required: o_debounced[1]=1 on 4th edge with o_rise[1] for 1 cycle.
//      - Then =0 on 4th edge after release with o_fall[1] for 1 cycle.
//   4. No commit at limit if input reverts:
//      - Stimulus: ch2 high 3 edges, low on the 4th.
//      - Required: no change, counter back to 0.
//   5. Mid-operation reset:
//      - Stimulus: ch3 high 3 edges, rst on the 4th edge, ch3 kept high.
//      - Required: no strobe at reset.
//      - Commit occurs 4 edges after rst deasserts.
//   6. LIMIT=1 build:
//      - Stimulus: toggle ch0 every cycle.
//      - Required: o_debounced follows with 1-cycle delay; rise/fall alternate each cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, counter-width helper and counter type for debounce_bank
package debounce_pkg;

    // Counter only has to reach LIMIT-1, so one bit is enough for LIMIT of 1 or 2.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

    localparam int unsigned DEFAULT_LIMIT = 20;
    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_LIMIT);

    typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one debounce channel: optional 2-flop sync (DEBOUNCE_SYNC_EN), run counter, level, strobes
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int   LIMIT       = DEFAULT_LIMIT,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bouncy,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_edge_nxt
);

    localparam int CW = cnt_width(LIMIT);
    typedef logic [CW-1:0] ch_cnt_t;
    localparam ch_cnt_t CNT_MAX = ch_cnt_t'(LIMIT - 1);

    logic    w_s;
    logic    r_level;
    logic    r_rise;
    logic    r_fall;
    ch_cnt_t r_cnt;
    logic    w_level_nxt;
    logic    w_rise_nxt;
    logic    w_fall_nxt;
    ch_cnt_t w_cnt_nxt;

`ifdef DEBOUNCE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RESET_LEVEL;
            r_sync2 <= RESET_LEVEL;
        end else begin
            r_sync1 <= i_bouncy;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = i_bouncy;
`endif

    // A matching sample restarts the run; commit only while the input still differs.
    always_comb begin
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (w_s == r_level) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_MAX) begin
            w_level_nxt = w_s;
            w_cnt_nxt   = '0;
            w_rise_nxt  = w_s;
            w_fall_nxt  = ~w_s;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= RESET_LEVEL;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign o_level    = r_level;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_edge_nxt = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - NUM_CH-channel debouncer with per-channel rise/fall strobes and a shared edge flag
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   NUM_CH         = 4,
    parameter int   DEBOUNCE_LIMIT = 20,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_bouncy,
    output logic [NUM_CH-1:0] o_debounced,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic              o_any_edge
);

    logic [NUM_CH-1:0] w_edge_nxt;
    logic              r_any_edge;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_ch #(
            .LIMIT       (DEBOUNCE_LIMIT),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_bouncy   (i_bouncy[g]),
            .o_level    (o_debounced[g]),
            .o_rise     (o_rise[g]),
            .o_fall     (o_fall[g]),
            .o_edge_nxt (w_edge_nxt[g])
        );
    end

    // Built from next-state strobes so the flag lands in the same cycle as o_rise/o_fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_edge <= 1'b0;
        end else begin
            r_any_edge <= |w_edge_nxt;
        end
    end

    assign o_any_edge = r_any_edge;

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank (LIMIT=4 bank plus a LIMIT=1 single channel)
module tb_debounce_bank;

`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i_bouncy = 4'h0;
    logic [3:0] o_debounced, o_rise, o_fall;
    logic       o_any_edge;
    logic [0:0] i_bouncy1 = 1'b0;
    logic [0:0] o_debounced1, o_rise1, o_fall1;
    logic       o_any_edge1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    debounce_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .RESET_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .i_bouncy(i_bouncy),
        .o_debounced(o_debounced), .o_rise(o_rise), .o_fall(o_fall), .o_any_edge(o_any_edge)
    );

    debounce_bank #(.NUM_CH(1), .DEBOUNCE_LIMIT(1), .RESET_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .i_bouncy(i_bouncy1),
        .o_debounced(o_debounced1), .o_rise(o_rise1), .o_fall(o_fall1), .o_any_edge(o_any_edge1)
    );

    // Reference: channels 0-3 are the LIMIT=4 bank, channel 4 is the LIMIT=1 instance.
    // A channel accepts a new level once its last LIMIT filter samples all differ from the held level.
    logic m_lvl[5], m_rise[5], m_fall[5], m_sp1[5], m_sp2[5];
    logic m_hist[5][$];
    logic [3:0] prevb = '0;
    logic rise0_seen;

    function automatic int lim(input int ch);
        return (ch < 4) ? 4 : 1;
    endfunction

    function automatic logic window_differs(input int ch);
        if (m_hist[ch].size() < lim(ch)) return 1'b0;
        foreach (m_hist[ch][k]) if (m_hist[ch][k] == m_lvl[ch]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r, input logic [4:0] b);
        logic s;
        for (int ch = 0; ch < 5; ch++) begin
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            if (r) begin
                m_lvl[ch] = 1'b0;
                m_sp1[ch] = 1'b0;
                m_sp2[ch] = 1'b0;
                m_hist[ch].delete();
            end else begin
                s = (LAT == 2) ? m_sp2[ch] : b[ch];
                m_sp2[ch] = m_sp1[ch];
                m_sp1[ch] = b[ch];
                m_hist[ch].push_back(s);
                while (m_hist[ch].size() > lim(ch)) void'(m_hist[ch].pop_front());
                if (window_differs(ch)) begin
                    m_lvl[ch]  = s;
                    m_rise[ch] = s;
                    m_fall[ch] = ~s;
                    m_hist[ch].delete();
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] b, input logic b1);
        logic [3:0] el, er, ef;
        @(negedge clk);
        rst = r;
        i_bouncy = b;
        i_bouncy1 = b1;
        @(posedge clk);
        model_edge(r, {b1, b});
        prevb = {prevb[2:0], b1};
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            el[ch] = m_lvl[ch];
            er[ch] = m_rise[ch];
            ef[ch] = m_fall[ch];
        end
        chk("model_level", {28'h0, o_debounced}, {28'h0, el});
        chk("model_rise", {28'h0, o_rise}, {28'h0, er});
        chk("model_fall", {28'h0, o_fall}, {28'h0, ef});
        chk("model_any_edge", {31'h0, o_any_edge}, {31'h0, |(er | ef)});
        chk("l1_level", {31'h0, o_debounced1}, {31'h0, m_lvl[4]});
        chk("l1_rise", {31'h0, o_rise1}, {31'h0, m_rise[4]});
        chk("l1_fall", {31'h0, o_fall1}, {31'h0, m_fall[4]});
        chk("l1_any_edge", {31'h0, o_any_edge1}, {31'h0, m_rise[4] | m_fall[4]});
        rise0_seen = rise0_seen | o_rise[0];
    endtask

    int hold[5];
    logic [4:0] rv;

    initial begin
        rise0_seen = 1'b0;
        // 1. reset with all inputs high, then release
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'hF, 1'b0);
            chk("rst_level", {28'h0, o_debounced}, 32'h0);
            chk("rst_strobes", {24'h0, o_rise, o_fall}, 32'h0);
            chk("rst_any_edge", {31'h0, o_any_edge}, 32'h0);
        end
        for (int i = 1; i <= 6 + LAT; i++) begin
            step(1'b0, 4'hF, 1'b0);
            chk("release_rise", {28'h0, o_rise}, (i == 4 + LAT) ? 32'hF : 32'h0);
            chk("release_any", {31'h0, o_any_edge}, (i == 4 + LAT) ? 32'h1 : 32'h0);
        end

        // 2. glitch reject on ch0
        step(1'b1, 4'h0, 1'b0);
        rise0_seen = 1'b0;
        for (int rep = 0; rep < 5; rep++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 4'h1, 1'b0);
            step(1'b0, 4'h0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0);
        chk("glitch_level", {31'h0, o_debounced[0]}, 32'h0);
        chk("glitch_no_rise", {31'h0, rise0_seen}, 32'h0);

        // 3. clean press and release on ch1
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 4'h2, 1'b0);
            chk("press_rise", {31'h0, o_rise[1]}, (i == 4 + LAT) ? 32'h1 : 32'h0);
            chk("press_level", {31'h0, o_debounced[1]}, (i >= 4 + LAT) ? 32'h1 : 32'h0);
        end
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 4'h0, 1'b0);
            chk("release_fall", {31'h0, o_fall[1]}, (i == 4 + LAT) ? 32'h1 : 32'h0);
            chk("release_level", {31'h0, o_debounced[1]}, (i >= 4 + LAT) ? 32'h0 : 32'h1);
        end

        // 4. no commit when ch2 reverts on the limit edge (twice: count must restart)
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 4'h4, 1'b0);
            for (int i = 0; i < 5; i++) begin
                step(1'b0, 4'h0, 1'b0);
                chk("revert_level", {31'h0, o_debounced[2]}, 32'h0);
                chk("revert_rise", {31'h0, o_rise[2]}, 32'h0);
            end
        end

        // 5. mid-operation reset discards the partial count on ch3
        for (int i = 0; i < 3; i++) step(1'b0, 4'h8, 1'b0);
        step(1'b1, 4'h8, 1'b0);
        chk("midrst_rise", {28'h0, o_rise}, 32'h0);
        chk("midrst_level", {28'h0, o_debounced}, 32'h0);
        for (int i = 1; i <= 6 + LAT; i++) begin
            step(1'b0, 4'h8, 1'b0);
            chk("midrst_commit", {31'h0, o_rise[3]}, (i == 4 + LAT) ? 32'h1 : 32'h0);
        end
        step(1'b1, 4'h0, 1'b0);

        // 6. LIMIT=1 instance follows a toggling input one cycle late
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 4'h0, i[0]);
            chk("l1_follow", {31'h0, o_debounced1}, {31'h0, prevb[LAT]});
            chk("l1_alt_rise", {31'h0, o_rise1}, {31'h0, prevb[LAT] & ~prevb[LAT+1]});
            chk("l1_alt_fall", {31'h0, o_fall1}, {31'h0, ~prevb[LAT] & prevb[LAT+1]});
        end

        // Randomised slow/bouncy inputs with occasional resets, checked against the model
        rv = '0;
        for (int ch = 0; ch < 5; ch++) hold[ch] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int ch = 0; ch < 5; ch++) begin
                if (hold[ch] == 0) begin
                    rv[ch] = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(1, 7);
                end
                hold[ch]--;
            end
            step(($urandom_range(0, 99) == 0), rv[3:0], rv[4]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
